// File: rtl/nmr_pkg.sv
// nmr_pkg: writer state encoding and status-word layout shared with the sequencer and PS driver
package nmr_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_TRIG, CAPTURE, DONE} writer_state_t;
  localparam int STS_DONE_BIT  = 31;
  localparam int STS_CLAMP_BIT = 30;
  localparam int STS_CNT_W     = 30;
endpackage

// File: rtl/nmr_sample_writer.sv
// nmr_sample_writer: stores decimated ADC samples into acquisition BRAM after a trigger edge
module nmr_sample_writer
  import nmr_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arm,
  input  logic              trig,
  input  logic [31:0]       cfg_nb_samples,
  input  logic [15:0]       cfg_decim,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_wdata,
  output logic              bram_en,
  output logic              bram_we,
  output logic [31:0]       sts,
  output logic              done
);
  localparam int CW = ADDR_W + 1;
  localparam logic [32:0] CAP = 33'(1) << ADDR_W;

  writer_state_t state;
  logic          trig_q;
  logic          clamped;
  logic [CW-1:0] cnt;
  logic [CW-1:0] target;
  logic [15:0]   dcnt;
  logic [15:0]   decim;
  logic [32:0]   nb_ext;
  logic          trig_rise;
  logic          last;
  logic          take;

  assign s_axis_tready = 1'b1;
  assign nb_ext        = {1'b0, cfg_nb_samples};
  assign trig_rise     = trig & ~trig_q;
  assign last          = cnt == target;
  assign take          = arm && state == CAPTURE && !last && s_axis_tvalid && dcnt == '0;

  assign sts[STS_DONE_BIT]    = done;
  assign sts[STS_CLAMP_BIT]   = clamped;
  assign sts[STS_CNT_W-1:0]   = STS_CNT_W'(cnt);

  // Sequencer-controlled capture FSM with inline trigger edge detect, decimation and write pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      trig_q     <= 1'b0;
      clamped    <= 1'b0;
      cnt        <= '0;
      target     <= '0;
      dcnt       <= '0;
      decim      <= '0;
      done       <= 1'b0;
      bram_en    <= 1'b0;
      bram_we    <= 1'b0;
      bram_addr  <= '0;
      bram_wdata <= '0;
    end else begin
      trig_q  <= trig;
      bram_en <= take;
      bram_we <= take;
      if (take) begin
        bram_addr  <= cnt[ADDR_W-1:0];
        bram_wdata <= s_axis_tdata;
      end
      if (!arm) begin
        state   <= IDLE;
        clamped <= 1'b0;
        cnt     <= '0;
        target  <= '0;
        dcnt    <= '0;
        decim   <= '0;
        done    <= 1'b0;
      end else begin
        case (state)
          IDLE: state <= WAIT_TRIG;
          WAIT_TRIG: if (trig_rise) begin
            clamped <= nb_ext > CAP;
            target  <= nb_ext > CAP ? CAP[CW-1:0] : cfg_nb_samples[CW-1:0];
            decim   <= cfg_decim;
            dcnt    <= '0;
            state   <= cfg_nb_samples == '0 ? DONE : CAPTURE;
            done    <= cfg_nb_samples == '0;
          end
          CAPTURE: if (last) begin
            state <= DONE;
            done  <= 1'b1;
          end else if (s_axis_tvalid) begin
            dcnt <= dcnt == decim ? '0 : dcnt + 16'd1;
            if (take) cnt <= cnt + CW'(1);
          end
          DONE: state <= DONE;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: doc/nmr_sample_writer.md
# nmr_sample_writer

Capture engine that stores ADC samples into acquisition BRAM under control of the NMR sequencer FSM. It is the responder to the sequencer's writer-control outputs: the sequencer releases it via `arm` and supplies the sample count. The writer then waits for the end-of-excitation trigger, stores decimated samples at consecutive BRAM addresses and reports progress and completion on a status word that is mirrored to the PS.

## Interface
Parameters:
- `ADDR_W`, 16, BRAM word-address width; capacity is 2^ADDR_W 32-bit words.
- `DATA_W`, 32, sample word width (two 16-bit ADC channels packed, ch B in [31:16], ch A in [15:0]).

Ports:
- `clk`  in  1  acquisition clock, all logic on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `arm`  in  1  high = run, low = hold idle (driven from sequencer `rst_writer`, synchronous).
- `trig`  in  1  start-of-acquisition strobe, level sampled; rising edge detected internally.
- `cfg_nb_samples`  in  32  number of words to store.
- `cfg_decim`  in  16  keep one valid sample out of (cfg_decim+1).
- `s_axis_tdata`  in  DATA_W  ADC sample.
- `s_axis_tvalid`  in  1  sample valid.
- `s_axis_tready`  out  1  constant 1; samples arriving outside CAPTURE are discarded.
- `bram_addr`  out  ADDR_W  write address.
- `bram_wdata`  out  DATA_W  write data.
- `bram_en`, `bram_we`  out  1  port enable and write enable, always asserted together.
- `sts`  out  32  [31] done, [30] clamped, [29:0] words written.
- `done`  out  1  capture complete, level.

## Operation
- States: IDLE, WAIT_TRIG, CAPTURE, DONE.
- IDLE: if `arm`=1, go to WAIT_TRIG. On entry, clear the counters and the latched target.
- WAIT_TRIG: on a `trig` rising edge (trig=1 and the registered previous value =0), latch the target and go to CAPTURE.
  - Target = min(cfg_nb_samples, 2^ADDR_W).
  - `clamped` = 1 when clamping occurred.
  - If the target is 0, go directly to DONE.
- CAPTURE: for each `s_axis_tvalid` beat, the decimation counter counts 0..cfg_decim.
  - On count 0, write the beat to `bram_addr`=word count, then increment the word count.
  - When the word count reaches the target, go to DONE.
- DONE: hold `done`=1 and the counters until `arm` falls.
- `arm`=0 in any state: next state is IDLE, counters are cleared, and no further writes occur. Any write already registered completes on that edge.
- `cfg_*` are sampled only at the trigger edge. Changes during CAPTURE are ignored.
- Word count width is ADDR_W+1. No address wrap: the write at address 2^ADDR_W-1 is the last possible write.

## Timing
- Reset values:
  - state=IDLE
  - `bram_en`=`bram_we`=0
  - `bram_addr`=0
  - `bram_wdata`=0
  - `sts`=0
  - `done`=0
  - `s_axis_tready`=1
- Trigger latency: trig rising at cycle t is detected at edge t. The first beat eligible for storage is the one valid at cycle t+1.
- Write latency: a beat accepted at cycle k produces `bram_we`=1 with registered addr/data during cycle k+1 (1-cycle pipeline).
- `sts[29:0]` increments in the same cycle as the corresponding `bram_we`.
- `done` asserts in the cycle after the final `bram_we`.
  - Target-0 case: `done` asserts 1 cycle after the trigger edge.
- Back-to-back valid beats with cfg_decim=0 produce one write per cycle with no bubbles.
- Reaching the target and having a valid beat in the same cycle: the extra beat is dropped; no write beyond the target.
- Trigger edge while in CAPTURE or DONE: ignored.

## Structure
- Shared package `nmr_pkg`:
  - state enum `writer_state_t`
  - `STS_DONE_BIT`=31, `STS_CLAMP_BIT`=30, `STS_CNT_W`=30
- These constants are shared with the sequencer status mux and the PS driver.
- Single module, no sub-modules. The trigger edge detector and the decimation counter are inline.

## Test plan
- Reset and idle: hold rst_n=0, then release with arm=0 and 100 valid beats. Required: no `bram_we`, sts=0, done=0.
- Basic capture: ADDR_W=16, cfg_nb_samples=8, cfg_decim=0, arm=1, trig pulse, then beats with data 0..15 continuous. Required:
  - 8 writes, addr 0..7, data 0..7
  - sts=0x8000_0008
  - done one cycle after the last write
- Decimation with gaps: cfg_decim=2, cfg_nb_samples=4, tvalid toggling 1/0. Required: writes of valid beats #0, #3, #6, #9 at addr 0..3.
- Clamp: ADDR_W=4, cfg_nb_samples=100. Required: exactly 16 writes, last addr 15, sts=0xC000_0010.
- Abort and rearm: arm falls after 3 writes of an 8-word capture. Required:
  - no further writes, state IDLE, sts=0 next cycle
  - after rearm and a new trigger, writes restart at addr 0
- Zero count and spurious trigger: cfg_nb_samples=0. Required: done=1 after 1 cycle with no writes. A second trig pulse while in DONE has no effect.
